// File: rtl/ccff_loader_pkg.sv
// Shared types, CRC constants and the serial CRC-16-CCITT step used by the
// CCFF bitstream loader.
package ccff_loader_pkg;

  localparam int CRC_W = 16;
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_FINISH = 2'd3
  } ccff_state_e;

  // MSB-feedback serial update, one data bit per call, no final XOR.
  function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                  input logic bit_in);
    logic             fb;
    logic [CRC_W-1:0] sh;
    fb = crc[CRC_W-1] ^ bit_in;
    sh = {crc[CRC_W-2:0], 1'b0};
    return fb ? (sh ^ CRC_POLY) : sh;
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator; clear has priority over enable.
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic             prog_clk,
  input  logic             pReset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] crc_d;

  // Next-state selection for the CRC register.
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC_INIT;
    end else if (enable) begin
      crc_d = crc16_step(crc_q, bit_in);
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC state register.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words into the CCFF chain head and optionally
// recirculates the chain once through its tail to CRC-check the contents.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 1024
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  ccff_state_e       state_q;
  logic [WORD_W-1:0] hold_q;
  logic              full_q;
  logic [BIT_W-1:0]  bit_idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              verify_q;
  logic              error_q;

  logic              cnt_last_s;
  logic              word_last_s;
  logic              load_shift_s;
  logic              load_last_s;
  logic              hold_empty_s;
  logic              ready_s;
  logic              accept_s;
  logic              crc_clear_s;
  logic              mismatch_s;
  logic [CRC_W-1:0]  crc_load_s;
  logic [CRC_W-1:0]  crc_rb_s;

  assign cnt_last_s   = (cnt_q == CNT_LAST);
  assign word_last_s  = (bit_idx_q == BIT_LAST);
  assign load_shift_s = (state_q == ST_LOAD) && full_q;
  assign load_last_s  = load_shift_s && cnt_last_s;
  assign hold_empty_s = load_shift_s && (word_last_s || cnt_last_s);
  // A new word may land in the cycle the current one drains, but never on the final chain bit.
  assign ready_s      = (state_q == ST_LOAD) && (!full_q || (word_last_s && !cnt_last_s));
  assign accept_s     = word_valid && ready_s;
  assign crc_clear_s  = (state_q == ST_IDLE) && start;
  assign mismatch_s   = verify_q && (crc_load_s != crc_rb_s);

  ccff_crc16_serial u_crc_load (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .enable   (load_shift_s),
    .clear    (crc_clear_s),
    .bit_in   (hold_q[0]),
    .crc_out  (crc_load_s)
  );

  ccff_crc16_serial u_crc_rb (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .enable   (state_q == ST_VERIFY),
    .clear    (crc_clear_s),
    .bit_in   (ccff_tail),
    .crc_out  (crc_rb_s)
  );

  // Loader FSM with holding register, bit counters and sticky error flag.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      full_q    <= 1'b0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      verify_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_LOAD;
            verify_q  <= verify_en;
            error_q   <= 1'b0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            bit_idx_q <= '0;
          end
        end
        ST_LOAD: begin
          if (load_shift_s) begin
            cnt_q     <= cnt_q + CNT_W'(1);
            hold_q    <= {1'b0, hold_q[WORD_W-1:1]};
            bit_idx_q <= bit_idx_q + BIT_W'(1);
          end
          if (accept_s) begin
            hold_q    <= word_in;
            full_q    <= 1'b1;
            bit_idx_q <= '0;
          end else if (hold_empty_s) begin
            full_q <= 1'b0;
          end
          if (load_last_s) begin
            state_q <= verify_q ? ST_VERIFY : ST_FINISH;
            cnt_q   <= '0;
            full_q  <= 1'b0;
          end
        end
        ST_VERIFY: begin
          if (cnt_last_s) begin
            state_q <= ST_FINISH;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_FINISH: begin
          if (mismatch_s) begin
            error_q <= 1'b1;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state; VERIFY closes the chain loop tail -> head.
  always_comb begin
    word_ready    = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_LOAD: begin
        word_ready    = ready_s;
        ccff_shift_en = full_q;
        ccff_head     = full_q && hold_q[0];
      end
      ST_VERIFY: begin
        ccff_shift_en = 1'b1;
        ccff_head     = ccff_tail;
      end
      ST_FINISH: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign error = error_q || ((state_q == ST_FINISH) && mismatch_s);

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench: each load pushes its expected outcome, a monitor pops it on done.
module tb_ccff_bitstream_loader;

  localparam int WW = 16;
  localparam int CL = 40;
  localparam logic [CL-1:0] FLIP_MASK = 40'h00_0002_0000;

  typedef struct {
    logic [CL-1:0] chain;
    logic          err;
    int            shifts;
  } exp_t;

  logic          prog_clk = 1'b0;
  logic          pReset_n = 1'b0;
  logic          start = 1'b0;
  logic          verify_en = 1'b0;
  logic [WW-1:0] word_in = '0;
  logic          word_valid = 1'b0;
  logic          word_ready;
  logic          ccff_head;
  logic          ccff_shift_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic          error;

  logic [CL-1:0] chain = '0;
  int            sc = 0;
  logic          flip_arm = 1'b0;

  exp_t sb_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   n_done = 0;
  int   idle_bad = 0;

  ccff_bitstream_loader #(.WORD_W(WW), .CHAIN_LEN(CL)) dut (
    .prog_clk      (prog_clk),
    .pReset_n      (pReset_n),
    .start         (start),
    .verify_en     (verify_en),
    .word_in       (word_in),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: bit 0 is the tail, so after a full load bit k holds the k-th loaded bit.
  always @(posedge prog_clk) begin
    if (ccff_shift_en) begin
      chain <= {ccff_head, chain[CL-1:1]} ^ ((flip_arm && sc == CL - 1) ? FLIP_MASK : '0);
      sc    <= sc + 1;
    end
    if (!busy) sc <= 0;
  end
  assign ccff_tail = chain[0];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: tracks the stream cycle by cycle and scores each done against the queue.
  initial begin
    int m_cyc, lc, vc, rem, acc, bad, last_shift;
    logic prev_done;
    exp_t e;
    m_cyc = 0; lc = 0; vc = 0; rem = 0; acc = 0; bad = 0; last_shift = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge prog_clk);
      #2;
      m_cyc++;
      if (!busy) begin
        if (ccff_shift_en || word_ready || done || ccff_head) idle_bad++;
        lc = 0; vc = 0; rem = 0; acc = 0; bad = 0;
      end else if (done) begin
        if (ccff_shift_en || word_ready || ccff_head) bad++;
        check("done_single_cycle", prev_done, 1'b0);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("chain_contents", chain, e.chain);
          check("error_at_done", error, e.err);
          check("shift_cycles", lc + vc, e.shifts);
          check("words_accepted", acc, 3);
          check("done_latency", m_cyc - last_shift, 1);
          check("stream_violations", bad, 0);
        end
        n_done++;
      end else if (lc < CL) begin
        if (ccff_shift_en !== (rem > 0)) bad++;
        if (!ccff_shift_en && ccff_head) bad++;
        if (ccff_shift_en) begin
          lc++; rem--; last_shift = m_cyc;
          if (lc == CL) rem = 0;
        end
        if (word_valid && word_ready) begin
          acc++; rem = WW;
        end
      end else begin
        if (!ccff_shift_en || ccff_head !== ccff_tail || word_ready) bad++;
        if (ccff_shift_en) begin
          vc++; last_shift = m_cyc;
        end
      end
      prev_done = done;
    end
  end

  task automatic do_op(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                       input logic [WW-1:0] w2, input bit ven, input bit tog,
                       input bit flip, input logic [CL-1:0] exp_chain,
                       input bit exp_err, input int abort_at, input bit poke);
    logic [WW-1:0] words [4];
    int   idx, cyc;
    exp_t e;
    words = '{w0, w1, w2, 16'h5A5A};
    if (abort_at < 0) begin
      e.chain = exp_chain; e.err = exp_err; e.shifts = ven ? 2 * CL : CL;
      sb_q.push_back(e);
    end
    flip_arm = flip;
    @(negedge prog_clk);
    start = 1'b1; verify_en = ven;
    @(negedge prog_clk);
    start = 1'b0; verify_en = 1'b0;
    #1 check("error_cleared_on_start", error, 1'b0);
    idx = 0; cyc = 0;
    while (busy && cyc < 400) begin
      if (abort_at >= 0 && sc == abort_at) begin
        word_valid = 1'b0;
        pReset_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_shift_en", ccff_shift_en, 1'b0);
        check("abort_word_ready", word_ready, 1'b0);
        check("abort_done", done, 1'b0);
        repeat (2) @(negedge prog_clk);
        pReset_n = 1'b1;
        break;
      end
      word_valid = tog ? (((cyc / 5) % 2) == 0) : 1'b1;
      word_in = words[idx];
      start = poke && (cyc == 10 || cyc == 60);
      #1;
      if (word_valid && word_ready && idx < 3) idx++;
      @(negedge prog_clk);
      cyc++;
    end
    word_valid = 1'b0; start = 1'b0; flip_arm = 1'b0;
    check("op_terminated", cyc >= 400, 1'b0);
  endtask

  initial begin
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_word_ready", word_ready, 1'b0);
    check("rst_shift_en", ccff_shift_en, 1'b0);
    check("rst_head", ccff_head, 1'b0);
    check("rst_error", error, 1'b0);
    repeat (2) @(negedge prog_clk);
    pReset_n = 1'b1;
    repeat (2) @(negedge prog_clk);

    do_op(16'hA5A5, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0, 40'hFF_0F0F_A5A5, 1'b0, -1, 1'b0);
    do_op(16'hA5A5, 16'h0F0F, 16'hFFFF, 1'b0, 1'b1, 1'b0, 40'hFF_0F0F_A5A5, 1'b0, -1, 1'b0);
    do_op(16'h1234, 16'hBEEF, 16'h00C3, 1'b1, 1'b0, 1'b0, 40'hC3_BEEF_1234, 1'b0, -1, 1'b1);
    do_op(16'hA5A5, 16'h0F0F, 16'hFFFF, 1'b1, 1'b0, 1'b1, 40'hFF_0F0D_A5A5, 1'b1, -1, 1'b0);
    repeat (3) @(negedge prog_clk);
    check("error_sticky_in_idle", error, 1'b1);
    do_op(16'hA5A5, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0, '0, 1'b0, 20, 1'b0);
    repeat (2) @(negedge prog_clk);
    check("post_abort_error", error, 1'b0);
    do_op(16'h8001, 16'h7E7E, 16'h0055, 1'b1, 1'b0, 1'b0, 40'h55_7E7E_8001, 1'b0, -1, 1'b0);

    repeat (5) @(negedge prog_clk);
    check("done_count", n_done, 5);
    check("scoreboard_drained", sb_q.size(), 0);
    check("idle_outputs_quiet", idle_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Configuration-side writer for the scan chain of configuration flip-flops (CCFF) that drives the mem/mem_inv select bits of the routing and LUT mux primitives.
- Accepts bitstream words over a valid/ready stream and serialises them into the chain head, one bit per prog_clk.
- Optionally recirculates the chain once through its tail to read back and CRC-check the loaded contents without destroying them.

Parameters:
WORD_W, 32, width of one bitstream word on word_in
CHAIN_LEN, 1024, number of CCFF bits in the chain (>= 2)
CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter (derived, not overridden)

Ports:
prog_clk  input  1  programming clock; all state on rising edge
pReset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a load; sampled only in IDLE
verify_en  input  1  sampled with start; 1 = run readback pass after load
word_in  input  WORD_W  bitstream word; bit 0 is shifted first
word_valid  input  1  word_in valid
word_ready  output  1  loader accepts word_in this cycle
ccff_head  output  1  serial data into chain head
ccff_shift_en  output  1  chain shifts on the rising edge ending this cycle
ccff_tail  input  1  serial data from chain tail (chain's last FF output)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse on completion
error  output  1  sticky readback CRC mismatch; cleared by the next accepted start

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; holding register empty; counters 0; CRC registers at CRC_INIT.
- States: IDLE, LOAD, VERIFY, FINISH.
- IDLE:
  - start=1 → LOAD next cycle; latch verify_en; clear error; zero bit counter; both CRCs ← CRC_INIT.
  - start in any other state is ignored.
- LOAD:
  - word_ready = 1 when the holding register is empty. A word is accepted when word_valid & word_ready.
  - Each cycle the holding register is non-empty, one bit is presented: ccff_shift_en=1, ccff_head=current bit, LSB first. The load CRC is updated with that bit, and the bit counter increments.
  - The holding register empties after its WORD_W-th bit, or immediately when the bit counter reaches CHAIN_LEN.
  - Any remaining high bits of the final word are discarded. Exactly ceil(CHAIN_LEN/WORD_W) words are consumed.
  - The word accepted in the cycle the holding register empties is shifted from the next cycle; there are no bubbles if valid is held.
  - Empty holding register → ccff_shift_en=0 and the chain stalls; stalls of any length are legal.
  - Counter reaches CHAIN_LEN → VERIFY if verify_en was latched, else FINISH. word_ready=0 from that cycle.
- VERIFY:
  - Exactly CHAIN_LEN cycles with ccff_shift_en=1 and ccff_head = ccff_tail (combinational recirculation path). The chain therefore ends holding its original contents.
  - ccff_tail is fed to the readback CRC each cycle. The first bit loaded emerges first, so bit order matches LOAD.
  - After the last cycle → FINISH.
- FINISH: done=1 for one cycle. If a verify ran and readback CRC ≠ load CRC, error ← 1 in the same cycle. Then → IDLE.
- ccff_shift_en is 0 in IDLE and FINISH; ccff_head is 0 whenever shift_en=0.
- word_ready is 0 outside LOAD. Words offered in IDLE are not consumed.
- pReset_n asserted mid-LOAD/VERIFY: immediate return to IDLE, shift_en=0, no done pulse. Chain contents are undefined and require a fresh load.
- CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, serial MSB-feedback update, one bit per cycle, no final XOR.

Decomposition:
- Package ccff_loader_pkg: state enum, CRC_POLY=16'h1021, CRC_INIT=16'hFFFF, CRC_W=16, and a function crc16_step(crc, bit).
- Sub-module ccff_crc16_serial (enable, clear, bit_in, crc_out), instantiated twice: load CRC and readback CRC.

Test Plan:
- CHAIN_LEN=40, WORD_W=16, verify_en=0, words 0xA5A5, 0x0F0F, 0xFFFF with valid held → 3 words accepted, 40 shift cycles with no gaps. Chain model holds 0xA5A5, 0x0F0F, then 8 ones. done pulses 1 cycle after the 40th shift; word 4 is never accepted.
- Same load with word_valid toggled 1/0 every 5 cycles → identical chain contents; shift_en low exactly while the holding register is empty.
- verify_en=1 with an ideal chain model → 40 extra shift cycles with head==tail. Chain contents unchanged, done pulses, error=0.
- verify_en=1 with chain-model bit 17 forced flipped after load → error=1 at done and stays 1. A following start clears it.
- Assert pReset_n low at shift cycle 20 → busy, shift_en, word_ready, and done drop to 0 asynchronously. A new start then loads 40 bits from bit 0.
- start pulsed during LOAD and during VERIFY → ignored. Exactly one done per accepted start.
